// File: rtl/mem_arbiter_if.sv
// Valid/ready memory port bundle shared by fetch, LSU and unified memory.
// The master modport is the requester side; slave is the responder side.
interface mem_arbiter_if;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  s_ready, s_rdata
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output s_ready, s_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (I/D) to one memory port arbiter with grant lock,
// round-robin or data-priority selection and a timeout watchdog.
module mem_arbiter #(
    parameter int D_PRIORITY  = 0,
    parameter int TIMEOUT_CYC = 256,
    parameter int TMO_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_arbiter_if.slave        i_port,
    mem_arbiter_if.slave        d_port,
    mem_arbiter_if.master       mem_port,
    output logic                o_bus_err,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);
    localparam logic             TMO_EN  = (TIMEOUT_CYC != 0);
    localparam logic             D_PRIO  = (D_PRIORITY != 0);

    state_t           state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;

    req_t i_req, d_req, mem_req;
    logic any_req, gnt_d, own_d, done;
    logic mem_valid, i_rdy, d_rdy, tmo;

    assign i_req   = '{i_port.m_addr, i_port.m_wdata, i_port.m_wstrb};
    assign d_req   = '{d_port.m_addr, d_port.m_wdata, d_port.m_wstrb};
    assign any_req = i_port.m_valid | d_port.m_valid;

    // rr_last_q: 1 = D was served last, so I wins the next tie
    assign gnt_d = d_port.m_valid &
                   (~i_port.m_valid | D_PRIO | ~rr_last_q);
    assign own_d = (state_q == LOCK_D);

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        mem_valid = 1'b0;
        mem_req   = req_q;
        i_rdy     = 1'b0;
        d_rdy     = 1'b0;
        tmo       = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_valid = any_req;
                mem_req   = gnt_d ? d_req : i_req;
                if (any_req) begin
                    if (mem_port.s_ready) begin
                        i_rdy     = ~gnt_d;
                        d_rdy     = gnt_d;
                        rr_last_d = gnt_d;
                    end else begin
                        req_d   = mem_req;
                        state_d = gnt_d ? LOCK_D : LOCK_I;
                        cnt_d   = TMO_W'(1);
                    end
                end
            end
            LOCK_I, LOCK_D: begin
                // a late ready in the compare cycle wins over the abort
                tmo       = TMO_EN & (cnt_q == TMO_LIM) &
                            ~mem_port.s_ready;
                mem_valid = ~tmo;
                done      = mem_port.s_ready | tmo;
                if (done) begin
                    i_rdy     = ~own_d & i_port.m_valid;
                    d_rdy     = own_d & d_port.m_valid;
                    rr_last_d = own_d;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b0;
            cnt_q     <= '0;
            req_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
        end
    end

    // every output is forced low while reset is held, comb paths included
    assign mem_port.m_valid = rst_n & mem_valid;
    assign mem_port.m_addr  = rst_n ? mem_req.addr  : '0;
    assign mem_port.m_wdata = rst_n ? mem_req.wdata : '0;
    assign mem_port.m_wstrb = rst_n ? mem_req.wstrb : '0;

    assign i_port.s_ready = rst_n & i_rdy;
    assign d_port.s_ready = rst_n & d_rdy;
    assign i_port.s_rdata = (rst_n && !tmo) ? mem_port.s_rdata : '0;
    assign d_port.s_rdata = (rst_n && !tmo) ? mem_port.s_rdata : '0;

    assign o_bus_err = rst_n & tmo;
    assign o_busy    = rst_n & (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin instance with a short watchdog plus a
// data-priority instance fed the same requests.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic err0, busy0, err1, busy1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter_if ip0 ();
    mem_arbiter_if dp0 ();
    mem_arbiter_if mp0 ();
    mem_arbiter_if ip1 ();
    mem_arbiter_if dp1 ();
    mem_arbiter_if mp1 ();

    assign ip1.m_valid = ip0.m_valid;
    assign ip1.m_addr  = ip0.m_addr;
    assign ip1.m_wdata = ip0.m_wdata;
    assign ip1.m_wstrb = ip0.m_wstrb;
    assign dp1.m_valid = dp0.m_valid;
    assign dp1.m_addr  = dp0.m_addr;
    assign dp1.m_wdata = dp0.m_wdata;
    assign dp1.m_wstrb = dp0.m_wstrb;
    assign mp1.s_ready = mp0.s_ready;
    assign mp1.s_rdata = mp0.s_rdata;

    mem_arbiter #(
        .D_PRIORITY (0),
        .TIMEOUT_CYC(4),
        .TMO_W      (16)
    ) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_port   (ip0),
        .d_port   (dp0),
        .mem_port (mp0),
        .o_bus_err(err0),
        .o_busy   (busy0)
    );

    mem_arbiter #(
        .D_PRIORITY (1),
        .TIMEOUT_CYC(256),
        .TMO_W      (16)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_port   (ip1),
        .d_port   (dp1),
        .mem_port (mp1),
        .o_bus_err(err1),
        .o_busy   (busy1)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia,
                         input logic dv, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [3:0] dws,
                         input logic rdy, input logic [31:0] rd);
        ip0.m_valid = iv;
        ip0.m_addr  = ia;
        ip0.m_wdata = 32'h0;
        ip0.m_wstrb = 4'h0;
        dp0.m_valid = dv;
        dp0.m_addr  = da;
        dp0.m_wdata = dwd;
        dp0.m_wstrb = dws;
        mp0.s_ready = rdy;
        mp0.s_rdata = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 32'h1234, 1, 32'h5678, 32'h9, 4'hF, 1, 32'hFFFF);
        #1;
        chk("rst_mem_valid", mp0.m_valid, 0);
        chk("rst_mem_addr", mp0.m_addr, 0);
        chk("rst_i_rdy", ip0.s_ready, 0);
        chk("rst_d_rdy", dp0.s_ready, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_err", err0, 0);

        // single I read, same-cycle memory
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h8000_0000, 0, 0, 0, 0, 1, 32'h13);
        #1;
        chk("i_rd_rdy", ip0.s_ready, 1);
        chk("i_rd_data", ip0.s_rdata, 32'h13);
        chk("i_rd_d_rdy", dp0.s_ready, 0);
        chk("i_rd_addr", mp0.m_addr, 32'h8000_0000);
        chk("i_rd_valid", mp0.m_valid, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("i_rd_idle", busy0, 0);

        // simultaneous requests: RR alternates D,I,..; priority always D
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 32'h1000, 1, 32'h2000, 0, 0, 1, k);
            #1;
            chk("rr_addr", mp0.m_addr, (k % 2 == 0) ? 32'h2000 : 32'h1000);
            chk("rr_d_rdy", dp0.s_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_i_rdy", ip0.s_ready, (k % 2 == 0) ? 0 : 1);
            chk("prio_addr", mp1.m_addr, 32'h2000);
            chk("prio_d_rdy", dp1.s_ready, 1);
        end

        // D store locked for 3 cycles with I waiting
        @(negedge clk);
        drive(1, 32'h100, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0);
        #1;
        chk("st_grant_addr", mp0.m_addr, 32'h8000_1000);
        chk("st_grant_busy", busy0, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(1, 32'h100, 1, 32'h5555, 32'h0, 4'h0, k == 3, 0);
            #1;
            chk("st_busy", busy0, 1);
            chk("st_addr", mp0.m_addr, 32'h8000_1000);
            chk("st_wstrb", mp0.m_wstrb, 4'hF);
            chk("st_wdata", mp0.m_wdata, 32'hDEAD_BEEF);
            chk("st_i_rdy", ip0.s_ready, 0);
            chk("st_d_rdy", dp0.s_ready, (k == 3) ? 1 : 0);
        end
        @(negedge clk);
        drive(1, 32'h100, 1, 32'h5555, 0, 0, 1, 0);
        #1;
        chk("st_next_i_rdy", ip0.s_ready, 1);
        chk("st_next_addr", mp0.m_addr, 32'h100);
        chk("st_next_d_rdy", dp0.s_ready, 0);

        // I granted, stalls, then flushed; completion coincides with
        // the watchdog compare and must not abort
        @(negedge clk);
        drive(1, 32'h2000_0040, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fl_grant_addr", mp0.m_addr, 32'h2000_0040);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive(k <= 2, (k <= 2) ? 32'h2000_0040 : 32'h0,
                  0, 0, 0, 0, k == 4, 32'h77);
            #1;
            chk("fl_valid", mp0.m_valid, 1);
            chk("fl_addr", mp0.m_addr, 32'h2000_0040);
            chk("fl_i_rdy", ip0.s_ready, 0);
            chk("fl_err", err0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fl_idle", busy0, 0);

        // watchdog abort on the 4th locked cycle
        @(negedge clk);
        drive(0, 0, 1, 32'h3000, 0, 0, 0, 32'hAAAA_5555);
        #1;
        chk("to_grant_addr", mp0.m_addr, 32'h3000);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            chk("to_wait_valid", mp0.m_valid, 1);
            chk("to_wait_err", err0, 0);
            chk("to_wait_rdy", dp0.s_ready, 0);
        end
        @(negedge clk);
        #1;
        chk("to_err", err0, 1);
        chk("to_valid", mp0.m_valid, 0);
        chk("to_d_rdy", dp0.s_ready, 1);
        chk("to_rdata", dp0.s_rdata, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h3004, 0, 0, 1, 32'hAAAA_5555);
        #1;
        chk("to_after_err", err0, 0);
        chk("to_after_busy", busy0, 0);
        chk("to_after_rdy", dp0.s_ready, 1);
        chk("to_after_data", dp0.s_rdata, 32'hAAAA_5555);

        // reset while locked on D
        @(negedge clk);
        drive(0, 0, 1, 32'h4000, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("rl_busy_pre", busy0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 1, 32'h4000, 0, 0, 1, 32'h11);
        #1;
        chk("rl_busy", busy0, 0);
        chk("rl_valid", mp0.m_valid, 0);
        chk("rl_d_rdy", dp0.s_ready, 0);
        chk("rl_addr", mp0.m_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h5000, 1, 32'h6000, 0, 0, 1, 32'h22);
        #1;
        chk("rl_tie_d_rdy", dp0.s_ready, 1);
        chk("rl_tie_i_rdy", ip0.s_ready, 0);
        chk("rl_tie_addr", mp0.m_addr, 32'h6000);

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares a single memory port between the instruction-fetch requester (I-port) and the load/store requester (D-port).
- Uses the pipeline's valid/ready memory handshake. Handshake completes in the cycle where m_valid && s_ready.
- Round-robin or fixed data-priority grant, with a grant lock while a transaction is outstanding, and a timeout watchdog that aborts hung slave transactions with a bus error.
- Sits between the fetch/LSU stages and the unified memory.

Parameters:
- D_PRIORITY, 0: 0 = round-robin between I and D; 1 = D always wins a simultaneous request.
- TIMEOUT_CYC, 256: cycles in a locked state before abort; 0 disables the watchdog.
- TMO_W, 16: width of the timeout counter; TIMEOUT_CYC must be < 2^TMO_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_m_valid  in  1  I-port request
- i_m_addr  in  32  I-port address
- i_m_wdata  in  32  I-port write data
- i_m_wstrb  in  4  I-port byte strobes (0 = read)
- i_s_ready  out  1  I-port handshake complete
- i_s_rdata  out  32  I-port read data
- d_m_valid, d_m_addr, d_m_wdata, d_m_wstrb  in  1/32/32/4  D-port request, same meaning as I-port
- d_s_ready  out  1  D-port handshake complete
- d_s_rdata  out  32  D-port read data
- mem_m_valid  out  1  request to memory
- mem_m_addr  out  32  address to memory
- mem_m_wdata  out  32  write data to memory
- mem_m_wstrb  out  4  byte strobes to memory
- mem_s_ready  in  1  memory handshake
- mem_s_rdata  in  32  memory read data
- o_bus_err  out  1  one-cycle pulse on timeout abort
- o_busy  out  1  high in a locked state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_last=I (so D wins the first tie), timeout counter=0, latched request=0. All outputs 0 immediately, including the combinational paths.
- States:
  - IDLE: no outstanding transaction.
  - LOCK_I / LOCK_D: a transaction was granted and is not yet complete.
- IDLE, grant selection:
  - Only one master valid: that master wins.
  - Both valid, D_PRIORITY=1: D wins.
  - Both valid, D_PRIORITY=0: the master not equal to rr_last wins.
- IDLE, forwarding (zero latency, combinational): mem_m_* = winner's m_*. mem_m_valid = 1 if any request is valid.
- IDLE, outcome:
  - mem_s_ready=1 same cycle: winner's s_ready=1; state stays IDLE; rr_last<=winner.
  - mem_s_ready=0: latch winner's addr/wdata/wstrb; go to LOCK_winner; counter<=1.
- LOCK_x, downstream: mem_m_valid=1 and mem_m_* = latched copy. The request is held even if master x drops m_valid (e.g. fetch flush). No other master is granted.
- LOCK_x, on mem_s_ready=1:
  - x_s_ready = x_m_valid. If x has withdrawn, the response is drained and discarded.
  - rr_last<=x; next state IDLE. The new arbitration happens in the following cycle, so there is no back-to-back grant in the completion cycle.
- LOCK_x, no mem_s_ready: counter increments.
- Timeout: TIMEOUT_CYC≠0 and counter==TIMEOUT_CYC with mem_s_ready still 0:
  - mem_m_valid=0 that cycle.
  - x_s_ready = x_m_valid, with x_s_rdata=0.
  - o_bus_err=1 for exactly one cycle.
  - rr_last<=x; next state IDLE.
  - mem_s_ready arriving in the same cycle as the timeout compare: treated as a normal completion; no error.
- Non-granted master: s_ready=0 always.
- Read data: i_s_rdata and d_s_rdata = mem_s_rdata, except the timeout cycle (0). Data is only meaningful with s_ready.
- o_busy = (state≠IDLE).
- Reset mid-transaction: lock dropped immediately; mem_m_valid=0; no response is delivered.
- Write/read distinction is carried only in wstrb; the arbiter does not inspect it.

Test Plan:
- Single I read, mem_s_ready same cycle: i_m_valid=1, addr=0x8000_0000, mem_s_rdata=0x0000_0013 -> i_s_ready=1 and i_s_rdata=0x13 in the same cycle; state stays IDLE; d_s_ready=0.
- Simultaneous I+D every cycle, D_PRIORITY=0, 1-cycle memory -> grants alternate D,I,D,I starting with D after reset; D_PRIORITY=1 -> D granted every time.
- D store, wstrb=0xF, addr=0x8000_1000, mem_s_ready after 3 cycles, i_m_valid high throughout -> mem_m_addr held at 0x8000_1000 in LOCK_D; o_busy=1 for 3 cycles; d_s_ready on cycle 3; I granted the next cycle.
- I granted, stalls 2 cycles, then i_m_valid drops (flush) -> mem_m_valid stays 1 with the latched addr until mem_s_ready; i_s_ready stays 0; return to IDLE.
- TIMEOUT_CYC=4, memory never ready -> o_bus_err pulse on the 4th locked cycle; requester s_ready=1 with rdata=0; mem_m_valid=0 that cycle; next request is served normally.
- rst_n asserted while in LOCK_D -> all outputs 0 immediately; after release, the first tie is granted to D.
